// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined logic unit: op encoding and flag bundle.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ZERO = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_AND  = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NAND = 3'b110,
    OP_ANDN = 3'b111
  } op_e;

  typedef struct packed {
    logic zero;
    logic ones;
    logic parity;
  } flags_t;

endpackage

// File: rtl/logic_core.sv
// Combinational bitwise operation and result flags for one WIDTH-bit operand pair.
module logic_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH-1:0] o_result,
  output flags_t           o_flags
);

  logic [WIDTH-1:0] w_res;

  function automatic logic odd_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Operation select; codes 000-011 keep the legacy 2-bit meaning.
  always_comb begin
    w_res = '0;
    case (i_op)
      OP_ZERO: w_res = '0;
      OP_OR:   w_res = i_a | i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_AND:  w_res = i_a & i_b;
      OP_NOR:  w_res = ~(i_a | i_b);
      OP_XNOR: w_res = ~(i_a ^ i_b);
      OP_NAND: w_res = ~(i_a & i_b);
      OP_ANDN: w_res = i_a & ~i_b;
      default: w_res = '0;
    endcase
  end

  assign o_result       = w_res;
  assign o_flags.zero   = (w_res == '0);
  assign o_flags.ones   = &w_res;
  assign o_flags.parity = odd_parity(w_res);

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_core; outputs come straight from S2.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [OP_W-1:0]  r_s1_op;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_result;
  flags_t           r_s2_flags;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic [WIDTH-1:0] w_result;
  flags_t           w_flags;

  // A stage may advance when it is empty or the stage after it is moving.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // S1: operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
      r_s1_op    <= in_op;
    end
  end

  logic_core #(.WIDTH(WIDTH)) u_core (
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .i_op     (r_s1_op),
    .o_result (w_result),
    .o_flags  (w_flags)
  );

  // S2: result and flags; data may refresh under a bubble since it is don't-care then
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_flags  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid  <= r_s1_valid;
      r_s2_result <= w_result;
      r_s2_flags  <= w_flags;
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_zero   = r_s2_flags.zero;
  assign out_ones   = r_s2_flags.ones;
  assign out_parity = r_s2_flags.parity;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined successor to the 16-bit combinational logic unit. Performs one of eight bitwise operations on two WIDTH-bit operands and returns the result with status flags. Uses a two-stage registered pipeline with valid/ready handshakes on both sides. Sits between the operand-issue logic and the writeback/flag path of the datapath.

Parameters:
WIDTH, 16, operand and result width in bits (must be >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and op presented
in_ready  output  1  block can accept this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  3  operation select
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  operation result
out_zero  output  1  result == 0
out_ones  output  1  result == all ones
out_parity  output  1  XOR-reduction of result (1 = odd count of ones)

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n is low, all valid flags, out_result and every out_* flag are cleared to 0. The pipeline is empty on release.
- Op encoding: 000 = zero (result 0), 001 = OR, 010 = XOR, 011 = AND, 100 = NOR, 101 = XNOR, 110 = NAND, 111 = ANDN (A & ~B). Codes 000–011 match the legacy 2-bit encoding zero-extended.
- Stage S1 registers a, b, op and s1_valid on input acceptance.
- Stage S2 registers result, zero, ones, parity and s2_valid, computed from S1.
- out_* are driven directly from S2 registers; there is no combinational path from in_* to out_*.
- Advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational; depends on out_ready)
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- S2 loads from S1 when s2_adv. s2_valid takes the value of s1_valid.
- S1 loads from the inputs when s1_adv. s1_valid takes the value of in_valid && in_ready.
- Latency: a result appears on out_valid exactly 2 cycles after input acceptance with no stall. Throughput is 1 op/cycle when out_ready is held high.
- Stall: while out_valid && !out_ready, all out_* hold stable. S1 holds while it is full. in_ready = 0 once both stages are full.
- Capacity: at most 2 ops in flight. Ordering is strictly FIFO; no op is dropped or duplicated.
- Simultaneous output transfer and full pipeline: S2 refills from S1 and S1 refills from the input in the same cycle, so there is no bubble.
- Bubbles: when S2 loads an empty S1, s2_valid becomes 0. S2 data registers may update, but the flags and result are don't-care while invalid.
- Reset mid-operation: in-flight ops are discarded. out_valid falls asynchronously with rst_n.
- Width rules: all ops are bitwise on WIDTH bits. zero/ones/parity are reductions over the full WIDTH.

Decomposition:
- Shared package logic_unit_pkg:
  - 3-bit op constants/enum: OP_ZERO, OP_OR, OP_XOR, OP_AND, OP_NOR, OP_XNOR, OP_NAND, OP_ANDN
  - flag bundle typedef
- One natural sub-module: logic_core, purely combinational, parametrised by WIDTH. It computes the result and the three flags from a, b, op, and is instantiated between S1 and S2.
- logic_unit_pipe contains only the pipeline registers and handshake logic.

Test Plan:
- OR, WIDTH=16, A=F0F0, B=FF00, out_ready=1, single beat at cycle 0:
  - expect out_valid at cycle 2
  - result FFF0, zero=0, ones=0, parity=0
- Op sweep, 8 back-to-back beats with A=00FF, B=0F0F, ops 000..111, out_ready=1:
  - expect results 0000, 0FFF, 0FF0, 000F, F000, F00F, FFF0, 00F0 on consecutive cycles 2..9
  - flags match each result, e.g. op 000 gives zero=1
- Flags, XOR A=B=1234 then NAND A=FFFF B=0000:
  - first result: 0000, zero=1, parity=0
  - second result: FFFF, ones=1, parity=0
- Backpressure:
  - stimulus: out_ready=0, offer 3 beats (OR, AND, XOR of A=000F, B=00F0)
  - first two accepted; in_ready=0 from the third offer cycle
  - out_* held at the first result 00FF for 3 stalled cycles
  - raise out_ready: results 00FF, 0000, 00FF in order, with the third accepted the cycle out_ready rises
- Reset mid-operation:
  - stimulus: both stages full, out_ready=0, pull rst_n low asynchronously between edges
  - out_valid and all out_* go 0 immediately
  - after release: in_ready=1, no stale result appears
- WIDTH=8 build, ANDN A=AA B=0F:
  - result A0, parity=0, ones=0, latency 2
